// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with a one-entry valid/ready output buffer.
// Optional macro PARITY_CHK_EN adds a trailing even-parity bit per word and drives o_par_err.
module serial_word_rx #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_sin,
    input  logic         i_sin_vld,
    input  logic         i_msb_first,
    input  logic         i_abort,
    output logic [N-1:0] o_dout,
    output logic         o_dout_vld,
    input  logic         i_dout_rdy,
    output logic         o_busy,
    output logic         o_ovf,
    input  logic         i_clr_ovf,
    output logic         o_par_err
);
`ifdef PARITY_CHK_EN
    localparam int W = N + 1;
`else
    localparam int W = N;
`endif
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_sreg;
    logic          r_msb;
    logic [N-1:0]  r_dout;
    logic          r_dout_vld;
    logic          r_busy;
    logic          r_ovf;

    logic          w_acc;
    logic          w_last;
    logic          w_order;
    logic          w_data;
    logic          w_load;
    logic          w_drop;
    logic [N-1:0]  w_shift;
    logic [N-1:0]  w_word;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_acc   = i_sin_vld & ~i_abort;
        w_last  = w_acc && (r_cnt == LAST);
        // The first bit of a word must use the live order input, not the stale latch.
        w_order = (r_cnt == '0) ? i_msb_first : r_msb;
        w_shift = w_order ? {r_sreg[N-2:0], i_sin} : {i_sin, r_sreg[N-1:1]};
`ifdef PARITY_CHK_EN
        w_data  = w_acc && (r_cnt < CW'(N));
        w_word  = r_sreg;
`else
        w_data  = w_acc;
        w_word  = w_shift;
`endif
        w_load  = w_last & (~r_dout_vld | i_dout_rdy);
        w_drop  = w_last & r_dout_vld & ~i_dout_rdy;
        if (i_abort || w_last) w_cnt_nxt = '0;
        else if (w_acc)        w_cnt_nxt = r_cnt + 1'b1;
        else                   w_cnt_nxt = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_sreg     <= '0;
            r_msb      <= 1'b0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
            if (i_abort)     r_sreg <= '0;
            else if (w_data) r_sreg <= w_shift;
            if (w_acc && r_cnt == '0) r_msb <= i_msb_first;
            if (w_load) begin
                r_dout     <= w_word;
                r_dout_vld <= 1'b1;
            end else if (r_dout_vld && i_dout_rdy) begin
                r_dout_vld <= 1'b0;
            end
            // A fresh overflow outranks a simultaneous clear.
            if (w_drop)         r_ovf <= 1'b1;
            else if (i_clr_ovf) r_ovf <= 1'b0;
        end
    end

`ifdef PARITY_CHK_EN
    logic r_par_err;
    always_ff @(posedge clk) begin
        if (rst)         r_par_err <= 1'b0;
        else if (w_load) r_par_err <= ^r_sreg ^ i_sin;
    end
    assign o_par_err = r_par_err;
`else
    assign o_par_err = 1'b0;
`endif

    assign o_dout     = r_dout;
    assign o_dout_vld = r_dout_vld;
    assign o_busy     = r_busy;
    assign o_ovf      = r_ovf;
endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (N=8); honours PARITY_CHK_EN when defined.
module tb_serial_word_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0, sin_vld = 1'b0, msb_first = 1'b0, abort = 1'b0;
    logic       dout_rdy = 1'b0, clr_ovf = 1'b0;
    logic [7:0] dout;
    logic       dout_vld, busy, ovf, par_err;
    int         n_cmp = 0, n_bad = 0;
    bit         bq[$];

    always #5 clk = ~clk;

    serial_word_rx #(.N(8)) dut (
        .clk(clk), .rst(rst), .i_sin(sin), .i_sin_vld(sin_vld), .i_msb_first(msb_first),
        .i_abort(abort), .o_dout(dout), .o_dout_vld(dout_vld), .i_dout_rdy(dout_rdy),
        .o_busy(busy), .o_ovf(ovf), .i_clr_ovf(clr_ovf), .o_par_err(par_err)
    );

    task automatic push_word(input logic [7:0] w, input bit m);
        for (int i = 0; i < 8; i++) bq.push_back(m ? w[7-i] : w[i]);
`ifdef PARITY_CHK_EN
        bq.push_back(^w);
`endif
    endtask

    task automatic send_bit(input bit b, input bit m, input bit rdy, input bit ab);
        @(negedge clk);
        sin = b; sin_vld = 1'b1; msb_first = m; dout_rdy = rdy; abort = ab;
        @(negedge clk);
        sin_vld = 1'b0; dout_rdy = 1'b0; abort = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit m, input bit rdy_last, input bit ab_last);
        bq.delete();
        push_word(w, m);
        foreach (bq[i]) begin
            bit lst;
            lst = (i == bq.size() - 1);
            send_bit(bq[i], m, rdy_last && lst, ab_last && lst);
        end
    endtask

    task automatic consume();
        @(negedge clk); dout_rdy = 1'b1;
        @(negedge clk); dout_rdy = 1'b0;
        n_cmp++; if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL consume_vld got %b want 0", dout_vld); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if ({dout, dout_vld, busy, ovf, par_err} !== 12'h0) begin
            n_bad++; $display("FAIL reset_outs got dout=%h vld=%b busy=%b ovf=%b perr=%b want all 0", dout, dout_vld, busy, ovf, par_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'hC0;
        for (int i = 0; i < 7; i++) begin
            send_bit(w[7-i], 1'b1, 1'b0, 1'b0);
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL msb_busy bit%0d got %b want 1", i + 1, busy); end
            n_cmp++; if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL msb_early_vld bit%0d got %b want 0", i + 1, dout_vld); end
        end
        send_bit(w[0], 1'b1, 1'b0, 1'b0);
`ifdef PARITY_CHK_EN
        send_bit(^w, 1'b1, 1'b0, 1'b0);
`endif
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL msb_busy_end got %b want 0", busy); end
        n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL msb_vld got %b want 1", dout_vld); end
        n_cmp++; if (dout !== 8'hC0) begin n_bad++; $display("FAIL msb_dout got %h want c0", dout); end
        consume();
    endtask

    task automatic test_lsb_first();
        send_word(8'h03, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL lsb_vld got %b want 1", dout_vld); end
        n_cmp++; if (dout !== 8'h03) begin n_bad++; $display("FAIL lsb_dout got %h want 03", dout); end
        consume();
    endtask

    task automatic test_overflow();
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (dout !== 8'h11) begin n_bad++; $display("FAIL ovf_dout got %h want 11", dout); end
        n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL ovf_vld got %b want 1", dout_vld); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", ovf); end
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", ovf); end
        send_word(8'h33, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (dout !== 8'h33) begin n_bad++; $display("FAIL accload_dout got %h want 33", dout); end
        n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL accload_vld got %b want 1", dout_vld); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL accload_ovf got %b want 0", ovf); end
        consume();
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy got %b want 1", busy); end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
        send_word(8'h81, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (dout !== 8'h81) begin n_bad++; $display("FAIL abort_dout got %h want 81", dout); end
        n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL abort_vld got %b want 1", dout_vld); end
        consume();
        send_word(8'hFF, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL abort_last_vld got %b want 0", dout_vld); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_last_busy got %b want 0", busy); end
        n_cmp++; if (dout !== 8'h81) begin n_bad++; $display("FAIL abort_last_dout got %h want 81", dout); end
    endtask

    task automatic test_mid_reset();
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_cmp++; if ({dout, dout_vld, busy, ovf, par_err} !== 12'h0) begin
            n_bad++; $display("FAIL midrst_outs got dout=%h vld=%b busy=%b ovf=%b perr=%b want all 0", dout, dout_vld, busy, ovf, par_err);
        end
        send_word(8'h5A, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (dout !== 8'h5A) begin n_bad++; $display("FAIL midrst_dout got %h want 5a", dout); end
        n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL midrst_vld got %b want 1", dout_vld); end
        consume();
    endtask

    task automatic test_back_to_back();
        int wlen;
        bq.delete();
        push_word(8'hA5, 1'b1);
        push_word(8'h3C, 1'b0);
        wlen = bq.size() / 2;
        dout_rdy = 1'b1;
        foreach (bq[i]) begin
            @(negedge clk);
            if (i == wlen) begin
                n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL b2b_vld1 got %b want 1", dout_vld); end
                n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL b2b_dout1 got %h want a5", dout); end
            end
            sin = bq[i]; sin_vld = 1'b1; msb_first = (i < wlen);
        end
        @(negedge clk);
        sin_vld = 1'b0;
        n_cmp++; if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL b2b_vld2 got %b want 1", dout_vld); end
        n_cmp++; if (dout !== 8'h3C) begin n_bad++; $display("FAIL b2b_dout2 got %h want 3c", dout); end
        dout_rdy = 1'b0;
        consume();
    endtask

    task automatic test_parity();
`ifdef PARITY_CHK_EN
        send_word(8'h07, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (dout !== 8'h07) begin n_bad++; $display("FAIL par_ok_dout got %h want 07", dout); end
        n_cmp++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL par_ok got %b want 0", par_err); end
        consume();
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (dout !== 8'h07) begin n_bad++; $display("FAIL par_bad_dout got %h want 07", dout); end
        n_cmp++; if (par_err !== 1'b1) begin n_bad++; $display("FAIL par_bad got %b want 1", par_err); end
        consume();
`else
        send_word(8'h07, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (dout !== 8'h07) begin n_bad++; $display("FAIL nopar_dout got %h want 07", dout); end
        n_cmp++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL nopar_perr got %b want 0", par_err); end
        send_bit(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nopar_9th_busy got %b want 1", busy); end
        n_cmp++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL nopar_9th_perr got %b want 0", par_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overflow();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
